bvh_trav_ctrl: RTL and testbench
================================

Name: bvh_trav_ctrl

Overview:
- Upstream sequencer for the ray/box intersection stage.
- Accepts one ray, walks the BVH depth-first from node 0, fetches each node's bounding box from node memory and issues it to the box-test stage.
- Consumes the box-test hit bit: misses are culled, interior hits descend into children, leaf hits emit a triangle range to the downstream triangle-test stage.

Parameters:
- FRA_BITS, 16: fixed-point fraction bits, Q(32-FRA_BITS).FRA_BITS; passed through only.
- NODE_AW, 16: node index/address width.
- STACK_DEPTH, 16: traversal stack entries; power of 2, at least 2.
- RIB_LAT, 2: cycles from o_box_en to a valid i_box_hit.
- TRI_W, 16: triangle base/count width.

Ports:
- i_clk, in, 1: clock.
- i_rst_n, in, 1: asynchronous active-low reset.
- i_ray_valid, in, 1: ray offered.
- i_ray, in, signed 32 [0:1][0:2]: [0] origin, [1] direction.
- o_ray_ready, out, 1: high only in IDLE.
- o_node_rd, out, 1: one-cycle node read request.
- o_node_addr, out, NODE_AW: node index.
- i_node_valid, in, 1: node data valid; arrives at least 1 cycle after o_node_rd.
- i_node_bbox, in, signed 32 [0:1][0:2]: [0] min, [1] max.
- i_node_leaf, in, 1: node is a leaf.
- i_node_left, in, NODE_AW: left child index.
- i_node_right, in, NODE_AW: right child index.
- i_node_tri_base, in, TRI_W: first triangle of the leaf.
- i_node_tri_cnt, in, TRI_W: number of triangles in the leaf.
- o_box_en, out, 1: one-cycle launch strobe to the box test.
- o_box_ray, out, signed 32 [0:1][0:2]: latched ray, held stable for the whole traversal.
- o_box_bbox, out, signed 32 [0:1][0:2]: latched bbox, held until the hit is sampled.
- i_box_hit, in, 1: intersects result.
- o_leaf_valid, out, 1: leaf triangle range available.
- i_leaf_ready, in, 1: downstream accepts the leaf range.
- o_leaf_tri_base, out, TRI_W: leaf triangle base.
- o_leaf_tri_cnt, out, TRI_W: leaf triangle count.
- o_busy, out, 1: traversal in progress.
- o_done, out, 1: one-cycle pulse at end of traversal.
- o_overflow, out, 1: sticky per ray; stack overflowed.
- o_stat_nodes, out, 16: nodes visited (optional feature).
- o_stat_leaves, out, 16: leaves emitted (optional feature).

Behaviour:
- Reset (async assert, synchronous release):
  - State IDLE, stack pointer 0.
  - All valid/strobe outputs, o_busy, o_done, o_overflow and stats are 0.
  - Latched data registers are 0.
- State machine states: IDLE, FETCH, WAIT_NODE, TEST, WAIT_TEST, LEAF_OUT, POP, DONE.
- IDLE:
  - o_ray_ready=1.
  - On i_ray_valid: latch ray, cur=0, clear o_overflow and stats, go to FETCH.
- FETCH:
  - o_node_rd=1 and o_node_addr=cur for exactly one cycle, then WAIT_NODE.
- WAIT_NODE:
  - Hold until i_node_valid.
  - Latch bbox, leaf flag, left, right, tri_base, tri_cnt; go to TEST.
- TEST:
  - o_box_en=1 for one cycle; load a latency counter with RIB_LAT; go to WAIT_TEST.
- WAIT_TEST:
  - Decrement the counter; sample i_box_hit in the cycle the counter reaches 0.
  - Miss: go to POP.
  - Hit on a leaf: go to LEAF_OUT.
  - Hit on an interior node: push right, set cur=left, go to FETCH.
- LEAF_OUT:
  - o_leaf_valid=1 with the range held stable until i_leaf_ready.
  - Transfer occurs in the cycle where valid and ready are both high; then go to POP.
- POP:
  - Stack empty: go to DONE.
  - Otherwise cur=top, pop, go to FETCH.
- DONE: o_done=1 for one cycle, then IDLE.
- o_busy=1 in every state except IDLE.
- Boundary conditions:
  - Push with the stack full: the right child is dropped, o_overflow is set (sticky until the next ray), and traversal continues with left.
  - Push and pop never occur in the same cycle.
  - Root miss: sequence is FETCH, WAIT_NODE, TEST, WAIT_TEST, POP, DONE; no leaf emitted.
  - Root is a leaf and hits: exactly one leaf is emitted.
  - i_leaf_ready held low stalls the block indefinitely in LEAF_OUT.
  - i_ray_valid outside IDLE is ignored (not accepted).
  - i_rst_n asserted mid-traversal aborts immediately to IDLE and discards the stack contents. No o_done pulse is issued.
  - i_node_valid outside WAIT_NODE is ignored.

Optional Feature:
- Macro: BVH_TRAV_STATS_EN.
- Defined:
  - o_stat_nodes increments on each entry to TEST.
  - o_stat_leaves increments on each leaf handshake.
  - Both saturate at 0xFFFF, clear on ray accept, and hold after DONE until the next ray.
- Undefined: both ports are tied to 0 and no counter logic is generated.

Decomposition:
- Package bvh_pkg holds:
  - fip_t (signed 32) and vec3_t.
  - ray_t and bbox_t ([0:1] of vec3_t).
  - node_t struct: bbox, leaf, left, right, tri_base, tri_cnt.
  - trav_state_e enum.
  - ROOT_IDX=0.
- Sub-module bvh_node_stack: LIFO, STACK_DEPTH x NODE_AW.
  - Ports: push, pop, wdata, rdata (top), empty, full; clear on reset.

Test Plan:
- Root miss: root bbox min (2,2,2), max (3,3,3) (Q16.16, 1.0=0x00010000); ray origin 0, dir (1,1,1); box model returns hit=0 → zero leaves, o_done pulse RIB_LAT+4 cycles after ray accept, o_overflow=0.
- Three-node tree: root interior (left=1, right=2); both children leaves (tri 0/4 and 4/2); all tests hit → leaves (0,4) then (4,2) in that order; 3 o_box_en pulses; o_done.
- Right child misses in the same tree → only leaf (0,4) is emitted; 3 box tests issued.
- Backpressure: hold i_leaf_ready=0 for 10 cycles → o_leaf_valid and the range stay stable, no further o_node_rd; the leaf transfers exactly once on release.
- Degenerate chain: 20 interior nodes each pushing a right child, STACK_DEPTH=16 → o_overflow=1 after the 17th push; traversal still completes with o_done.
- Mid-traversal reset: assert i_rst_n=0 during WAIT_TEST → all outputs 0 asynchronously; a new ray is accepted cleanly with an empty stack (stats show 1 node after its first TEST when BVH_TRAV_STATS_EN is defined).

Source files
------------

// File: rtl/bvh_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : bvh_pkg
//  Purpose  : Shared fixed-point, ray/box and node types for BVH traversal.
//  Revision : 1.0
// ============================================================================
package bvh_pkg;

   localparam int PKG_NODE_AW = 16;
   localparam int PKG_TRI_W   = 16;
   localparam int ROOT_IDX    = 0;

   typedef logic signed [31:0] fip_t;
   typedef fip_t  [0:2] vec3_t;
   typedef vec3_t [0:1] ray_t;     // [0] origin, [1] direction
   typedef vec3_t [0:1] bbox_t;    // [0] min, [1] max

   typedef struct packed {
      bbox_t                  bbox;
      logic                   leaf;
      logic [PKG_NODE_AW-1:0] left;
      logic [PKG_NODE_AW-1:0] right;
      logic [PKG_TRI_W-1:0]   tri_base;
      logic [PKG_TRI_W-1:0]   tri_cnt;
   } node_t;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_WAIT_NODE = 3'd2,
      ST_TEST      = 3'd3,
      ST_WAIT_TEST = 3'd4,
      ST_LEAF_OUT  = 3'd5,
      ST_POP       = 3'd6,
      ST_DONE      = 3'd7
   } trav_state_e;

endpackage
`default_nettype wire

// File: rtl/bvh_trav_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : bvh_trav_ctrl_if
//  Purpose  : Ray, node-memory, box-test and leaf-output bundle of the
//             traversal controller (master = controller, slave = environment).
//  Revision : 1.0
// ============================================================================
interface bvh_trav_ctrl_if
   import bvh_pkg::*;
#(
   parameter int NODE_AW = 16,
   parameter int TRI_W   = 16
);
   logic               i_ray_valid;
   ray_t               i_ray;
   logic               o_ray_ready;

   logic               o_node_rd;
   logic [NODE_AW-1:0] o_node_addr;
   logic               i_node_valid;
   bbox_t              i_node_bbox;
   logic               i_node_leaf;
   logic [NODE_AW-1:0] i_node_left;
   logic [NODE_AW-1:0] i_node_right;
   logic [TRI_W-1:0]   i_node_tri_base;
   logic [TRI_W-1:0]   i_node_tri_cnt;

   logic               o_box_en;
   ray_t               o_box_ray;
   bbox_t              o_box_bbox;
   logic               i_box_hit;

   logic               o_leaf_valid;
   logic               i_leaf_ready;
   logic [TRI_W-1:0]   o_leaf_tri_base;
   logic [TRI_W-1:0]   o_leaf_tri_cnt;

   modport master (
      input  i_ray_valid, i_ray,
      output o_ray_ready,
      output o_node_rd, o_node_addr,
      input  i_node_valid, i_node_bbox, i_node_leaf, i_node_left, i_node_right,
      input  i_node_tri_base, i_node_tri_cnt,
      output o_box_en, o_box_ray, o_box_bbox,
      input  i_box_hit,
      output o_leaf_valid, o_leaf_tri_base, o_leaf_tri_cnt,
      input  i_leaf_ready
   );

   modport slave (
      output i_ray_valid, i_ray,
      input  o_ray_ready,
      input  o_node_rd, o_node_addr,
      output i_node_valid, i_node_bbox, i_node_leaf, i_node_left, i_node_right,
      output i_node_tri_base, i_node_tri_cnt,
      input  o_box_en, o_box_ray, o_box_bbox,
      output i_box_hit,
      input  o_leaf_valid, o_leaf_tri_base, o_leaf_tri_cnt,
      output i_leaf_ready
   );
endinterface
`default_nettype wire

// File: rtl/bvh_node_stack.sv
`default_nettype none
// ============================================================================
//  Module   : bvh_node_stack
//  Purpose  : LIFO of pending node indices; rdata always shows the top entry.
//  Revision : 1.0
// ============================================================================
module bvh_node_stack #(
   parameter int STACK_DEPTH = 16,
   parameter int NODE_AW     = 16
) (
   input  wire logic               i_clk,
   input  wire logic               i_rst_n,
   input  wire logic               i_push,
   input  wire logic               i_pop,
   input  wire logic [NODE_AW-1:0] i_wdata,
   output logic      [NODE_AW-1:0] o_rdata,
   output logic                    o_empty,
   output logic                    o_full
);
   localparam int PW = $clog2(STACK_DEPTH);

   logic [NODE_AW-1:0] r_mem [STACK_DEPTH];
   logic [PW:0]        r_sp;
   logic [PW-1:0]      w_top_idx;

   // Wraps to DEPTH-1 when the stack is full (sp low bits are zero).
   assign w_top_idx = r_sp[PW-1:0] - 1'b1;
   assign o_rdata   = r_mem[w_top_idx];
   assign o_empty   = (r_sp == '0);
   assign o_full    = r_sp[PW];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sp <= '0;
      end else if (i_push && !o_full) begin
         r_sp <= r_sp + 1'b1;
      end else if (i_pop && !o_empty) begin
         r_sp <= r_sp - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push && !o_full) begin
         r_mem[r_sp[PW-1:0]] <= i_wdata;
      end
   end
endmodule
`default_nettype wire

// File: rtl/bvh_trav_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : bvh_trav_ctrl
//  Purpose  : Depth-first BVH walker feeding the box-test and triangle stages.
//             Optional BVH_TRAV_STATS_EN adds node/leaf visit counters.
//  Revision : 1.0
// ============================================================================
module bvh_trav_ctrl
   import bvh_pkg::*;
#(
   parameter int FRA_BITS    = 16,
   parameter int NODE_AW     = 16,
   parameter int STACK_DEPTH = 16,
   parameter int RIB_LAT     = 2,
   parameter int TRI_W       = 16
) (
   input  wire logic        i_clk,
   input  wire logic        i_rst_n,
   bvh_trav_ctrl_if.master  bus,
   output logic             o_busy,
   output logic             o_done,
   output logic             o_overflow,
   output logic [15:0]      o_stat_nodes,
   output logic [15:0]      o_stat_leaves
);
   localparam int LW = (RIB_LAT < 2) ? 1 : $clog2(RIB_LAT + 1);

   if (STACK_DEPTH < 2 || (STACK_DEPTH & (STACK_DEPTH - 1)) != 0 ||
       FRA_BITS < 0 || FRA_BITS > 31 || RIB_LAT < 1) begin : g_bad_cfg
      $error("bvh_trav_ctrl: unsupported parameter set");
   end

   trav_state_e        r_state;
   logic [NODE_AW-1:0] r_cur, r_left, r_right;
   ray_t               r_ray;
   bbox_t              r_bbox;
   logic               r_leaf;
   logic [TRI_W-1:0]   r_base, r_cnt;
   logic [LW-1:0]      r_lat;
   logic               r_node_rd, r_box_en, r_leaf_valid, r_busy, r_done, r_ovf;

   logic               w_hit_now, w_push, w_pop, w_empty, w_full;
   logic [NODE_AW-1:0] w_top;

   assign w_hit_now = (r_state == ST_WAIT_TEST) && (r_lat == LW'(1)) && bus.i_box_hit;
   assign w_push    = w_hit_now && !r_leaf && !w_full;
   assign w_pop     = (r_state == ST_POP) && !w_empty;

   bvh_node_stack #(
      .STACK_DEPTH (STACK_DEPTH),
      .NODE_AW     (NODE_AW)
   ) u_stack (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (w_push),
      .i_pop   (w_pop),
      .i_wdata (r_right),
      .o_rdata (w_top),
      .o_empty (w_empty),
      .o_full  (w_full)
   );

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state      <= ST_IDLE;
         r_cur        <= '0;
         r_left       <= '0;
         r_right      <= '0;
         r_ray        <= '0;
         r_bbox       <= '0;
         r_leaf       <= 1'b0;
         r_base       <= '0;
         r_cnt        <= '0;
         r_lat        <= '0;
         r_node_rd    <= 1'b0;
         r_box_en     <= 1'b0;
         r_leaf_valid <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         r_node_rd <= 1'b0;
         r_box_en  <= 1'b0;
         r_done    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.i_ray_valid) begin
                  r_ray     <= bus.i_ray;
                  r_cur     <= NODE_AW'(ROOT_IDX);
                  r_ovf     <= 1'b0;
                  r_busy    <= 1'b1;
                  r_node_rd <= 1'b1;
                  r_state   <= ST_FETCH;
               end
            end
            ST_FETCH: r_state <= ST_WAIT_NODE;
            ST_WAIT_NODE: begin
               if (bus.i_node_valid) begin
                  r_bbox   <= bus.i_node_bbox;
                  r_leaf   <= bus.i_node_leaf;
                  r_left   <= bus.i_node_left;
                  r_right  <= bus.i_node_right;
                  r_base   <= bus.i_node_tri_base;
                  r_cnt    <= bus.i_node_tri_cnt;
                  r_box_en <= 1'b1;
                  r_state  <= ST_TEST;
               end
            end
            ST_TEST: begin
               r_lat   <= LW'(RIB_LAT);
               r_state <= ST_WAIT_TEST;
            end
            ST_WAIT_TEST: begin
               if (r_lat == LW'(1)) begin
                  if (!bus.i_box_hit) begin
                     r_state <= ST_POP;
                  end else if (r_leaf) begin
                     r_leaf_valid <= 1'b1;
                     r_state      <= ST_LEAF_OUT;
                  end else begin
                     // A full stack drops the right subtree; the left one is still walked.
                     if (w_full) r_ovf <= 1'b1;
                     r_cur     <= r_left;
                     r_node_rd <= 1'b1;
                     r_state   <= ST_FETCH;
                  end
               end else begin
                  r_lat <= r_lat - 1'b1;
               end
            end
            ST_LEAF_OUT: begin
               if (bus.i_leaf_ready) begin
                  r_leaf_valid <= 1'b0;
                  r_state      <= ST_POP;
               end
            end
            ST_POP: begin
               if (w_empty) begin
                  r_done  <= 1'b1;
                  r_state <= ST_DONE;
               end else begin
                  r_cur     <= w_top;
                  r_node_rd <= 1'b1;
                  r_state   <= ST_FETCH;
               end
            end
            ST_DONE: begin
               r_busy  <= 1'b0;
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef BVH_TRAV_STATS_EN
   logic [15:0] r_stat_nodes, r_stat_leaves;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_stat_nodes  <= '0;
         r_stat_leaves <= '0;
      end else if (r_state == ST_IDLE && bus.i_ray_valid) begin
         r_stat_nodes  <= '0;
         r_stat_leaves <= '0;
      end else begin
         if (r_state == ST_TEST && r_stat_nodes != 16'hFFFF)
            r_stat_nodes <= r_stat_nodes + 1'b1;
         if (r_state == ST_LEAF_OUT && bus.i_leaf_ready && r_stat_leaves != 16'hFFFF)
            r_stat_leaves <= r_stat_leaves + 1'b1;
      end
   end

   assign o_stat_nodes  = r_stat_nodes;
   assign o_stat_leaves = r_stat_leaves;
`else
   assign o_stat_nodes  = '0;
   assign o_stat_leaves = '0;
`endif

   assign bus.o_ray_ready     = (r_state == ST_IDLE);
   assign bus.o_node_rd       = r_node_rd;
   assign bus.o_node_addr     = r_cur;
   assign bus.o_box_en        = r_box_en;
   assign bus.o_box_ray       = r_ray;
   assign bus.o_box_bbox      = r_bbox;
   assign bus.o_leaf_valid    = r_leaf_valid;
   assign bus.o_leaf_tri_base = r_base;
   assign bus.o_leaf_tri_cnt  = r_cnt;
   assign o_busy              = r_busy;
   assign o_done              = r_done;
   assign o_overflow          = r_ovf;
endmodule
`default_nettype wire

// File: tb/tb_bvh_trav_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bvh_trav_ctrl
//  Purpose  : Scoreboard bench for bvh_trav_ctrl with a DFS reference model.
//  Revision : 1.0
// ============================================================================
module tb_bvh_trav_ctrl;
   import bvh_pkg::*;

   localparam int NODE_AW = 16, TRI_W = 16, STACK_DEPTH = 16, RIB_LAT = 2;
   localparam int MAXN = 64;
   localparam logic signed [31:0] ONE = 32'sh0001_0000;

   logic clk = 1'b0, rst_n = 1'b0;
   always #5 clk = ~clk;

   bvh_trav_ctrl_if #(.NODE_AW(NODE_AW), .TRI_W(TRI_W)) bus ();
   logic        busy, done, ovf;
   logic [15:0] st_nodes, st_leaves;

   bvh_trav_ctrl #(
      .FRA_BITS(16), .NODE_AW(NODE_AW), .STACK_DEPTH(STACK_DEPTH),
      .RIB_LAT(RIB_LAT), .TRI_W(TRI_W)
   ) u_dut (
      .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_busy(busy), .o_done(done),
      .o_overflow(ovf), .o_stat_nodes(st_nodes), .o_stat_leaves(st_leaves)
   );

   typedef struct packed { logic [TRI_W-1:0] base; logic [TRI_W-1:0] cnt; } leaf_t;
   typedef struct { int tests; bit ov; int leaves; } done_t;

   node_t mem [MAXN];
   bit    hit_tbl [MAXN];
   leaf_t exp_leaf [$];
   done_t exp_done [$];
   ray_t  cur_ray;
   int    n_chk = 0, n_fail = 0;
   int    cyc = 0, box_cnt = 0, accept_cyc = 0, done_cyc = 0;
   int    ready_mode = 2;   // 0 hold low, 1 random, 2 always high

   function automatic void check(string nm, longint act, longint exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endfunction

   always @(posedge clk) cyc++;

   // Node memory: data one cycle after the read strobe; junk valid during FETCH.
   bit rd_pend = 1'b0;
   int rd_addr = 0, last_addr = 0;
   always @(negedge clk) begin
      bus.i_node_valid = 1'b0;
      if (!rst_n) begin
         rd_pend = 1'b0;
      end else if (rd_pend) begin
         bus.i_node_bbox     = mem[rd_addr].bbox;
         bus.i_node_leaf     = mem[rd_addr].leaf;
         bus.i_node_left     = mem[rd_addr].left;
         bus.i_node_right    = mem[rd_addr].right;
         bus.i_node_tri_base = mem[rd_addr].tri_base;
         bus.i_node_tri_cnt  = mem[rd_addr].tri_cnt;
         bus.i_node_valid    = 1'b1;
         last_addr           = rd_addr;
         rd_pend             = 1'b0;
      end else if (bus.o_node_rd && $urandom_range(1) == 1) begin
         for (int a = 0; a < 2; a++)
            for (int b = 0; b < 3; b++) bus.i_node_bbox[a][b] = $urandom;
         bus.i_node_leaf     = $urandom_range(1) == 1;
         bus.i_node_left     = NODE_AW'($urandom);
         bus.i_node_right    = NODE_AW'($urandom);
         bus.i_node_tri_base = TRI_W'($urandom);
         bus.i_node_tri_cnt  = TRI_W'($urandom);
         bus.i_node_valid    = 1'b1;
      end
      if (rst_n && bus.o_node_rd) begin
         rd_pend = 1'b1;
         rd_addr = int'(bus.o_node_addr) % MAXN;
      end
   end

   // Box-test model: answer from the hit table of the node just fetched.
   always @(negedge clk) begin
      if (rst_n && bus.o_box_en) begin
         box_cnt++;
         bus.i_box_hit = hit_tbl[last_addr];
         check("box_ray", longint'(bus.o_box_ray == cur_ray), 1);
         check("box_bbox", longint'(bus.o_box_bbox == mem[last_addr].bbox), 1);
      end
   end

   // Leaf consumer and scoreboard.
   always @(negedge clk) begin
      case (ready_mode)
         0:       bus.i_leaf_ready = 1'b0;
         1:       bus.i_leaf_ready = ($urandom_range(1) == 1);
         default: bus.i_leaf_ready = 1'b1;
      endcase
      if (rst_n && bus.o_leaf_valid && bus.i_leaf_ready) begin
         if (exp_leaf.size() == 0) begin
            check("unexpected_leaf", 1, 0);
         end else begin
            leaf_t e;
            e = exp_leaf.pop_front();
            check("leaf_base", bus.o_leaf_tri_base, e.base);
            check("leaf_cnt", bus.o_leaf_tri_cnt, e.cnt);
         end
      end
   end

   // End-of-traversal monitor.
   always @(negedge clk) begin
      if (rst_n && done) begin
         done_cyc = cyc;
         if (exp_done.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            done_t d;
            d = exp_done.pop_front();
            check("box_tests", box_cnt, d.tests);
            check("overflow", ovf, d.ov);
            check("busy_in_done", busy, 1);
            check("leaves_left", exp_leaf.size(), 0);
`ifdef BVH_TRAV_STATS_EN
            check("stat_nodes", st_nodes, d.tests);
            check("stat_leaves", st_leaves, d.leaves);
`else
            check("stat_nodes", st_nodes, 0);
            check("stat_leaves", st_leaves, 0);
`endif
         end
      end
   end

   // Reference: plain depth-first walk with a bounded explicit stack.
   function automatic void model();
      int st[$];
      int cur = ROOT_IDX, tests = 0, lv = 0, guard = 0;
      bit ov = 1'b0;
      while (guard < 10000) begin
         guard++;
         tests++;
         if (hit_tbl[cur]) begin
            if (mem[cur].leaf) begin
               exp_leaf.push_back('{mem[cur].tri_base, mem[cur].tri_cnt});
               lv++;
            end else begin
               if (st.size() < STACK_DEPTH) st.push_back(int'(mem[cur].right));
               else ov = 1'b1;
               cur = int'(mem[cur].left);
               continue;
            end
         end
         if (st.size() == 0) break;
         cur = st.pop_back();
      end
      exp_done.push_back('{tests, ov, lv});
   endfunction

   function automatic void clear_mem();
      for (int i = 0; i < MAXN; i++) begin
         for (int a = 0; a < 2; a++)
            for (int b = 0; b < 3; b++) mem[i].bbox[a][b] = $urandom;
         mem[i].leaf = 1'b1;
         mem[i].left = '0;
         mem[i].right = '0;
         mem[i].tri_base = TRI_W'($urandom_range(4095));
         mem[i].tri_cnt = TRI_W'($urandom_range(15, 1));
         hit_tbl[i] = 1'b1;
      end
   endfunction

   function automatic void three_node();
      clear_mem();
      mem[0].leaf = 1'b0; mem[0].left = 1; mem[0].right = 2;
      mem[1].tri_base = 0; mem[1].tri_cnt = 4;
      mem[2].tri_base = 4; mem[2].tri_cnt = 2;
   endfunction

   function automatic void gen_tree(int nmax);
      int nxt = 1;
      clear_mem();
      for (int i = 0; i < nxt; i++) begin
         if (nxt + 2 <= nmax && $urandom_range(2) != 0) begin
            mem[i].leaf = 1'b0;
            mem[i].left = NODE_AW'(nxt);
            mem[i].right = NODE_AW'(nxt + 1);
            nxt += 2;
         end
         hit_tbl[i] = ($urandom_range(3) != 0);
      end
   endfunction

   function automatic ray_t rand_ray();
      ray_t r;
      for (int a = 0; a < 2; a++)
         for (int b = 0; b < 3; b++) r[a][b] = $urandom;
      return r;
   endfunction

   task automatic send_ray(input ray_t r);
      int t = 0;
      @(negedge clk);
      while (!bus.o_ray_ready && t < 200) begin @(negedge clk); t++; end
      check("ray_ready_wait", longint'(bus.o_ray_ready), 1);
      bus.i_ray = r;
      bus.i_ray_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.i_ray_valid = 1'b0;
      cur_ray = r;
      box_cnt = 0;
      accept_cyc = cyc;
   endtask

   task automatic wait_idle();
      int t = 0;
      while (exp_done.size() != 0 && t < 5000) begin @(negedge clk); t++; end
      if (t >= 5000) begin
         check("traversal_timeout", 1, 0);
         exp_done.delete();
         exp_leaf.delete();
      end
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(string tag);
      check({tag, "_node_rd"}, bus.o_node_rd, 0);
      check({tag, "_box_en"}, bus.o_box_en, 0);
      check({tag, "_leaf_valid"}, bus.o_leaf_valid, 0);
      check({tag, "_busy"}, busy, 0);
      check({tag, "_done"}, done, 0);
      check({tag, "_overflow"}, ovf, 0);
      check({tag, "_stats"}, {st_nodes, st_leaves}, 0);
      check({tag, "_box_ray"}, longint'(bus.o_box_ray == '0), 1);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      ray_t r;
      int t;
      leaf_t held;
      bus.i_ray_valid = 1'b0;
      bus.i_ray = '0;
      bus.i_node_valid = 1'b0;
      bus.i_node_bbox = '0;
      bus.i_node_leaf = 1'b0;
      bus.i_node_left = '0;
      bus.i_node_right = '0;
      bus.i_node_tri_base = '0;
      bus.i_node_tri_cnt = '0;
      bus.i_box_hit = 1'b0;
      bus.i_leaf_ready = 1'b1;
      clear_mem();

      // Reset state
      #23;
      check_outputs_zero("rst");
      check("rst_ray_ready", bus.o_ray_ready, 1);
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      check_outputs_zero("post_rst");

      // Root miss: done RIB_LAT+4 cycles after accept
      clear_mem();
      for (int b = 0; b < 3; b++) begin
         mem[0].bbox[0][b] = 2 * ONE;
         mem[0].bbox[1][b] = 3 * ONE;
      end
      mem[0].leaf = 1'b0; mem[0].left = 1; mem[0].right = 2;
      hit_tbl[0] = 1'b0;
      model();
      r = '0;
      for (int b = 0; b < 3; b++) r[1][b] = ONE;
      send_ray(r);
      wait_idle();
      check("root_miss_latency", done_cyc - accept_cyc, RIB_LAT + 4);
      check("idle_busy", busy, 0);

      // Three-node tree all hit; stray ray_valid while busy must be ignored
      three_node();
      model();
      send_ray(rand_ray());
      bus.i_ray = rand_ray();
      bus.i_ray_valid = 1'b1;
      repeat (4) @(negedge clk);
      bus.i_ray_valid = 1'b0;
      wait_idle();

      // Right child misses
      three_node();
      hit_tbl[2] = 1'b0;
      model();
      send_ray(rand_ray());
      wait_idle();

      // Backpressure
      three_node();
      model();
      ready_mode = 0;
      send_ray(rand_ray());
      t = 0;
      while (!bus.o_leaf_valid && t < 100) begin @(negedge clk); t++; end
      check("bp_leaf_seen", bus.o_leaf_valid, 1);
      held = '{bus.o_leaf_tri_base, bus.o_leaf_tri_cnt};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid_held", bus.o_leaf_valid, 1);
         check("bp_range_held", longint'({bus.o_leaf_tri_base, bus.o_leaf_tri_cnt} == held), 1);
         check("bp_no_node_rd", bus.o_node_rd, 0);
      end
      ready_mode = 2;
      wait_idle();

      // Degenerate chain overflows a 16-deep stack
      clear_mem();
      for (int i = 0; i < 20; i++) begin
         mem[i].leaf = 1'b0;
         mem[i].left = NODE_AW'(i + 1);
         mem[i].right = NODE_AW'(21 + i);
         mem[21 + i].tri_base = TRI_W'(i);
         mem[21 + i].tri_cnt = 1;
      end
      mem[20].tri_base = 100; mem[20].tri_cnt = 1;
      model();
      check("chain_model_overflow", exp_done[0].ov, 1);
      send_ray(rand_ray());
      wait_idle();
      check("overflow_sticky", ovf, 1);
      three_node();
      model();
      send_ray(rand_ray());
      check("overflow_cleared", ovf, 0);
      wait_idle();

      // Mid-traversal reset during WAIT_TEST
      three_node();
      model();
      send_ray(rand_ray());
      t = 0;
      while (!bus.o_box_en && t < 100) begin @(negedge clk); t++; end
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check_outputs_zero("mid_rst");
      exp_leaf.delete();
      exp_done.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      three_node();
      hit_tbl[0] = 1'b0;
      model();
      send_ray(rand_ray());
      t = 0;
      while (!bus.o_box_en && t < 100) begin @(negedge clk); t++; end
      @(negedge clk);
`ifdef BVH_TRAV_STATS_EN
      check("post_rst_stat_nodes", st_nodes, 1);
`else
      check("post_rst_stat_nodes", st_nodes, 0);
`endif
      wait_idle();

      // Random trees with random backpressure
      ready_mode = 1;
      for (int n = 0; n < 40; n++) begin
         gen_tree($urandom_range(MAXN - 1, 1));
         model();
         send_ray(rand_ray());
         wait_idle();
      end
      ready_mode = 2;

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
`default_nettype wire
